// File: rtl/neuron_act_collector_if.sv
// Result stream from the activation collector to the next layer or the AXI writer.
// The master drives data, valid and last. The slave drives ready.
interface neuron_act_collector_if #(
  parameter int DWIDTH = 16
);
  logic [DWIDTH-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/neuron_act_collector.sv
// neuron_act_collector: captures neuron results, applies an optional ReLU and tags
// the last neuron of each layer. Results are buffered in a FWFT FIFO and streamed
// out over valid/ready. End-of-layer is reported with m_last and a layer_done pulse.
//
// state   | meaning
// IDLE    | no layer in progress
// COLLECT | layer started, last neuron not yet captured
// DRAIN   | last neuron captured, waiting for it to leave the FIFO
module neuron_act_collector #(
  parameter int DWIDTH     = 16,
  parameter int NUM_NEURON = 10,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [DWIDTH-1:0]             neuron_out,
  input  logic                          neuron_done,
  input  logic                          relu_en,
  neuron_act_collector_if.master        m_if,
  output logic [$clog2(NUM_NEURON):0]   neuron_idx,
  output logic                          busy,
  output logic                          layer_done,
  output logic                          overflow
);
  localparam int IW = $clog2(NUM_NEURON) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURON - 1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [DWIDTH-1:0] act_q;
  logic              last_q;
  logic              wr_q;
  logic [DWIDTH:0]   mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, pop, do_write;
  logic              cap_last, drain_exit;
  logic              pending, pending_last;

  assign cap_last = (neuron_idx == LAST_IDX);
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = m_if.m_valid && m_if.m_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_write = wr_q && (!full || pop);

  assign m_if.m_valid = !empty;
  assign {m_if.m_last, m_if.m_data} = mem[rd_ptr[AW-1:0]];
  assign busy = (state != IDLE);

  // The layer ends when its last entry is popped. If that entry was dropped on
  // overflow, the layer ends once the FIFO and the write stage have both emptied.
  assign drain_exit = (state == DRAIN) &&
                      ((pop && m_if.m_last) || (empty && !wr_q));

  // Stage A: capture the result with ReLU, tag it and advance the layer index.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      act_q      <= '0;
      last_q     <= 1'b0;
      wr_q       <= 1'b0;
      neuron_idx <= '0;
    end else begin
      wr_q <= neuron_done;
      if (neuron_done) begin
        act_q      <= (relu_en && neuron_out[DWIDTH-1]) ? '0 : neuron_out;
        last_q     <= cap_last;
        neuron_idx <= cap_last ? '0 : neuron_idx + IW'(1);
      end
    end
  end

  // Stage B: FIFO write and pop, plus the sticky overflow flag.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr[AW-1:0]] <= {last_q, act_q};
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_q && full && !pop) overflow <= 1'b1;
    end
  end

  // FSM state register, the next-layer pending flags and the layer_done pulse.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      layer_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      layer_done <= drain_exit;
      if (state != DRAIN || drain_exit) begin
        pending      <= 1'b0;
        pending_last <= 1'b0;
      end else if (neuron_done) begin
        pending      <= 1'b1;
        pending_last <= pending_last | cap_last;
      end
    end
  end

  // FSM next state. A capture in the exit cycle itself counts as next-layer work.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (neuron_done) state_nxt = cap_last ? DRAIN : COLLECT;
      COLLECT: if (neuron_done && cap_last) state_nxt = DRAIN;
      DRAIN: begin
        if (drain_exit) begin
          if (pending_last || (neuron_done && cap_last)) state_nxt = DRAIN;
          else if (pending || neuron_done)               state_nxt = COLLECT;
          else                                           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_neuron_act_collector.sv
// Directed bench for neuron_act_collector (NUM_NEURON=4, DEPTH=16). Expected
// entries are queued when each pulse is driven and compared as the DUT pops them.
module tb_neuron_act_collector;
  localparam int DW = 16;
  localparam int NN = 4;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [DW-1:0] neuron_out = '0;
  logic          neuron_done = 1'b0;
  logic          relu_en = 1'b0;
  logic [2:0]    neuron_idx;
  logic          busy, layer_done, overflow;

  neuron_act_collector_if #(.DWIDTH(DW)) sif ();

  neuron_act_collector #(.DWIDTH(DW), .NUM_NEURON(NN), .DEPTH(DP)) dut (
    .clk(clk), .nreset(nreset), .neuron_out(neuron_out), .neuron_done(neuron_done),
    .relu_en(relu_en), .m_if(sif.master), .neuron_idx(neuron_idx), .busy(busy),
    .layer_done(layer_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_pops = 0;
  int ld_count = 0;
  int model_idx = 0;
  bit ld_chk = 1'b0;
  bit prev_last_pop = 1'b0;
  logic [DW:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One capture pulse; the expected entry is queued unless it will be dropped.
  task automatic pulse(input logic [DW-1:0] d, input logic r, input bit will_push);
    logic          last;
    logic [DW-1:0] act;
    last = (model_idx == NN - 1);
    act  = (r && d[DW-1]) ? '0 : d;
    if (will_push) exp_q.push_back({last, act});
    model_idx = last ? 0 : model_idx + 1;
    neuron_out  = d;
    relu_en     = r;
    neuron_done = 1'b1;
    @(posedge clk); #1;
    neuron_done = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    exp_q.delete();
    model_idx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int k;
    sif.m_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || sif.m_valid) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, (exp_q.size() == 0 && !sif.m_valid), 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare popped entries with the scoreboard and check layer_done timing.
  always @(negedge clk) begin
    if (!nreset) begin
      prev_last_pop = 1'b0;
    end else begin
      if (layer_done) ld_count++;
      if (ld_chk) chk("layer_done_timing", layer_done, prev_last_pop);
      prev_last_pop = sif.m_valid && sif.m_ready && sif.m_last;
      if (sif.m_valid && sif.m_ready) begin
        n_pops++;
        if (exp_q.size() == 0) chk("unexpected_pop", {sif.m_last, sif.m_data}, 17'h1ffff);
        else chk("pop_entry", {sif.m_last, sif.m_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int ld0, p0;
    sif.m_ready = 1'b0;
    #2;
    chk("rst_valid", sif.m_valid, 0);
    chk("rst_busy", busy, 0);
    do_reset();
    chk("rst_m_data", sif.m_data, 0);
    chk("rst_m_last", sif.m_last, 0);
    chk("rst_idx", neuron_idx, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_overflow", overflow, 0);

    // ReLU layer with consumer always ready
    ld_chk = 1'b1;
    ld0 = ld_count;
    sif.m_ready = 1'b1;
    pulse(16'h0400, 1'b1, 1'b1);
    pulse(16'hFC00, 1'b1, 1'b1);
    pulse(16'h0000, 1'b1, 1'b1);
    pulse(16'h7FFF, 1'b1, 1'b1);
    drain("t1_drain");
    wait_cycles(3);
    chk("t1_ld_count", ld_count - ld0, 1);
    chk("t1_busy_after", busy, 0);

    // pass-through and two-cycle latency
    sif.m_ready = 1'b0;
    pulse(16'hFC00, 1'b0, 1'b1);
    chk("t2_valid_t1", sif.m_valid, 0);
    @(posedge clk); #1;
    chk("t2_valid_t2", sif.m_valid, 1);
    pulse(16'h8000, 1'b0, 1'b1);
    drain("t2_drain");

    // overflow on the 17th entry
    ld_chk = 1'b0;
    do_reset();
    sif.m_ready = 1'b0;
    for (int i = 0; i < 17; i++) pulse(DW'(i), 1'b0, (i < 16));
    wait_cycles(3);
    chk("t3_overflow", overflow, 1);
    chk("t3_valid", sif.m_valid, 1);
    p0 = n_pops;
    drain("t3_drain");
    chk("t3_pop_count", n_pops - p0, 16);

    // push and pop in the same cycle on a full FIFO
    do_reset();
    sif.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) pulse(DW'(16'h0100 + i), 1'b0, 1'b1);
    wait_cycles(3);
    chk("t4_overflow_full", overflow, 0);
    p0 = n_pops;
    pulse(16'h0AAA, 1'b0, 1'b1);
    sif.m_ready = 1'b1;
    @(posedge clk); #1;
    sif.m_ready = 1'b0;
    wait_cycles(2);
    chk("t4_overflow_after", overflow, 0);
    drain("t4_drain");
    chk("t4_pop_count", n_pops - p0, 17);

    // next-layer capture while draining
    do_reset();
    ld_chk = 1'b1;
    ld0 = ld_count;
    sif.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) pulse(DW'(16'h0010 + i), 1'b0, 1'b1);
    wait_cycles(6);
    chk("t5_ld_count", ld_count - ld0, 1);
    chk("t5_busy", busy, 1);
    chk("t5_idx", neuron_idx, 1);
    drain("t5_drain");

    // reset in the middle of a layer
    ld_chk = 1'b0;
    do_reset();
    sif.m_ready = 1'b0;
    pulse(16'h1111, 1'b0, 1'b1);
    pulse(16'h2222, 1'b0, 1'b1);
    wait_cycles(2);
    #3 nreset = 1'b0;
    #1;
    chk("t6_rst_valid", sif.m_valid, 0);
    chk("t6_rst_idx", neuron_idx, 0);
    chk("t6_rst_busy", busy, 0);
    do_reset();
    ld_chk = 1'b1;
    ld0 = ld_count;
    sif.m_ready = 1'b1;
    pulse(16'h0001, 1'b0, 1'b1);
    pulse(16'h0002, 1'b0, 1'b1);
    pulse(16'h0003, 1'b0, 1'b1);
    pulse(16'h0004, 1'b0, 1'b1);
    drain("t6_drain");
    wait_cycles(3);
    chk("t6_ld_count", ld_count - ld0, 1);
    ld_chk = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
